adc_par16_responder: RTL and testbench

Synthesizable model of the external 16-bit parallel ADC, sitting on the ADC side of the CONVST/CS/RD/WR/SHDN/EOC/DB[15:0] bus. It answers the FPGA's ADC controller exactly as the converter does: it starts conversions on CONVST, signals completion on EOC, and drives the result on DB during CS/RD reads. It is used for hardware-in-loop bring-up of the force-measurement path without a load cell attached, and as the DUT-side peer in controller simulations.

---
 rtl/adc_par16_responder.sv | 235 +++++++++++++++++++++++
 tb/tb_adc_par16_responder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_par16_responder.sv
// adc_par16_responder
// Behavioural stand-in for a 16-bit parallel-output ADC. It answers an FPGA ADC
// controller on the CONVST/CS/RD/WR/SHDN/EOC/DB bus. Conversions are started
// by a CONVST falling edge and completion is flagged on EOC. The captured
// result is returned on DB during CS/RD reads.
//
// State table
//   state    | meaning
//   IDLE     | waiting for a CONVST falling edge
//   CONVERT  | conversion in progress, cnt counting down to 0
//   DONE     | result in data_reg, EOC low, waiting for a read
//   SHUTDOWN | SHDN asserted, EOC high, conversions aborted
//   WAKE     | SHDN released, wake_cnt counting down before IDLE
//
// Parameters
//   CONV_CYCLES : conversion time in clk cycles (>= 2)
//   WAKE_CYCLES : cycles from SHDN release until CONVST is accepted (>= 1)
//   RAMP_INIT   : reset value of the internal ramp source
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   CONVST     in   conversion start, active-low, falling edge starts
//   CS         in   chip select, active-low
//   RD         in   read strobe, active-low
//   WR         in   write strobe, active-low, accepted and ignored
//   SHDN       in   shutdown, active-high
//   sample_in  in   external sample value [15:0]
//   sample_sel in   source select: 0 = internal ramp, 1 = sample_in
//   DB_out     out  read data [15:0], zero while DB_oe is low
//   DB_oe      out  output enable for the top-level tristate
//   EOC        out  end of conversion, active-low
//   overrun    out  sticky: CONVST during a conversion or result overwritten unread
`timescale 1ns/1ps

module adc_par16_responder #(
   parameter int unsigned CONV_CYCLES = 8,
   parameter int unsigned WAKE_CYCLES = 4,
   parameter logic [15:0] RAMP_INIT   = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        CONVST,
   input  logic        CS,
   input  logic        RD,
   input  logic        WR,
   input  logic        SHDN,
   input  logic [15:0] sample_in,
   input  logic        sample_sel,
   output logic [15:0] DB_out,
   output logic        DB_oe,
   output logic        EOC,
   output logic        overrun
);

   localparam int unsigned CW = (CONV_CYCLES > 2) ? $clog2(CONV_CYCLES) : 1;
   localparam int unsigned WW = $clog2(WAKE_CYCLES + 1);
   localparam logic [CW-1:0] CONV_LOAD = CW'(CONV_CYCLES - 1);
   localparam logic [WW-1:0] WAKE_LOAD = WW'(WAKE_CYCLES);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      CONVERT  = 3'd1,
      DONE     = 3'd2,
      SHUTDOWN = 3'd3,
      WAKE     = 3'd4
   } state_t;

   state_t state, state_nxt;

   logic          convst_meta, convst_sync, convst_dly;
   logic          cs_meta, cs_sync;
   logic          rd_meta, rd_sync, rd_dly;
   logic          shdn_meta, shdn_sync;

   logic [CW-1:0] cnt, cnt_nxt;
   logic [WW-1:0] wake_cnt, wake_cnt_nxt;
   logic [15:0]   hold_reg, hold_nxt;
   logic [15:0]   data_reg, data_nxt;
   logic [15:0]   ramp, ramp_nxt;
   logic          eoc_nxt, overrun_nxt;
   logic          rd_req;

   logic          convst_fall, rd_fall, read_strobe;
   logic [15:0]   sample_src;

   // The write strobe exists only so the pinout matches the real converter.
   logic          wr_unused;
   assign wr_unused = WR;

   // Control lines idle high except SHDN, so the synchronizers reset to the
   // idle level and no spurious edge is seen when reset releases.
   always_ff @(posedge clk) begin
      if (rst) begin
         convst_meta <= 1'b1;
         convst_sync <= 1'b1;
         convst_dly  <= 1'b1;
         cs_meta     <= 1'b1;
         cs_sync     <= 1'b1;
         rd_meta     <= 1'b1;
         rd_sync     <= 1'b1;
         rd_dly      <= 1'b1;
         shdn_meta   <= 1'b0;
         shdn_sync   <= 1'b0;
      end else begin
         convst_meta <= CONVST;
         convst_sync <= convst_meta;
         convst_dly  <= convst_sync;
         cs_meta     <= CS;
         cs_sync     <= cs_meta;
         rd_meta     <= RD;
         rd_sync     <= rd_meta;
         rd_dly      <= rd_sync;
         shdn_meta   <= SHDN;
         shdn_sync   <= shdn_meta;
      end
   end

   assign convst_fall = convst_dly & ~convst_sync;
   assign rd_fall     = rd_dly & ~rd_sync;
   assign read_strobe = rd_fall & ~cs_sync;

   // sample_in is captured directly at the start edge; the controller holds
   // it steady around CONVST, so it is not synchronized.
   assign sample_src  = sample_sel ? sample_in : ramp;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         wake_cnt <= '0;
         hold_reg <= 16'h0000;
         data_reg <= 16'h0000;
         ramp     <= RAMP_INIT;
         EOC      <= 1'b1;
         overrun  <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         wake_cnt <= wake_cnt_nxt;
         hold_reg <= hold_nxt;
         data_reg <= data_nxt;
         ramp     <= ramp_nxt;
         EOC      <= eoc_nxt;
         overrun  <= overrun_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      wake_cnt_nxt = wake_cnt;
      hold_nxt     = hold_reg;
      data_nxt     = data_reg;
      ramp_nxt     = ramp;
      eoc_nxt      = EOC;
      overrun_nxt  = overrun;

      if (shdn_sync) begin
         // Shutdown overrides everything; an in-flight conversion is dropped
         // and the held/result registers keep their contents.
         state_nxt = SHUTDOWN;
         eoc_nxt   = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (convst_fall) begin
                  hold_nxt  = sample_src;
                  cnt_nxt   = CONV_LOAD;
                  eoc_nxt   = 1'b1;
                  state_nxt = CONVERT;
               end
            end
            CONVERT: begin
               if (convst_fall) begin
                  overrun_nxt = 1'b1;
               end
               if (cnt == '0) begin
                  data_nxt  = hold_reg;
                  eoc_nxt   = 1'b0;
                  ramp_nxt  = ramp + 16'd1;
                  state_nxt = DONE;
               end else begin
                  cnt_nxt = cnt - 1'b1;
               end
            end
            DONE: begin
               // A new start outranks a read arriving in the same cycle and
               // means the pending result is about to be overwritten.
               if (convst_fall) begin
                  hold_nxt    = sample_src;
                  cnt_nxt     = CONV_LOAD;
                  eoc_nxt     = 1'b1;
                  overrun_nxt = 1'b1;
                  state_nxt   = CONVERT;
               end else if (read_strobe) begin
                  eoc_nxt   = 1'b1;
                  state_nxt = IDLE;
               end
            end
            SHUTDOWN: begin
               eoc_nxt      = 1'b1;
               wake_cnt_nxt = WAKE_LOAD;
               state_nxt    = WAKE;
            end
            WAKE: begin
               if (wake_cnt <= WW'(1)) begin
                  state_nxt = IDLE;
               end else begin
                  wake_cnt_nxt = wake_cnt - 1'b1;
               end
            end
            default: begin
               state_nxt = IDLE;
               eoc_nxt   = 1'b1;
            end
         endcase
      end
   end

   // Read path is independent of the FSM: one stage to form the request from
   // the synchronized strobes and one more to present DB.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_req <= 1'b0;
         DB_oe  <= 1'b0;
         DB_out <= 16'h0000;
      end else begin
         rd_req <= ~cs_sync & ~rd_sync;
         DB_oe  <= rd_req;
         DB_out <= rd_req ? data_reg : 16'h0000;
      end
   end

endmodule

// File: tb/tb_adc_par16_responder.sv
`timescale 1ns/1ps

module tb_adc_par16_responder;

   localparam int          CONV_CYCLES = 8;
   localparam int          WAKE_CYCLES = 4;
   localparam logic [15:0] RAMP_INIT_B = 16'hFFFF;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        CONVST = 1'b1;
   logic        CS = 1'b1;
   logic        RD = 1'b1;
   logic        WR = 1'b1;
   logic        SHDN = 1'b0;
   logic [15:0] sample_in = 16'h0000;
   logic        sample_sel = 1'b0;

   logic [15:0] db_out_a, db_out_b;
   logic        db_oe_a, db_oe_b;
   logic        eoc_a, eoc_b;
   logic        ovr_a, ovr_b;

   int n_total = 0;
   int n_pass  = 0;

   // reference model: counts of completed conversions and last result
   logic [15:0] m_ramp   = 16'h0000;
   logic [15:0] m_data_a = 16'h0000;
   logic [15:0] m_data_b = 16'h0000;
   bit          m_unread = 1'b0;
   bit          m_ovr    = 1'b0;

   logic [15:0] exp_a[$];
   logic [15:0] exp_b[$];

   always #5 clk = ~clk;

   adc_par16_responder #(
      .CONV_CYCLES(CONV_CYCLES),
      .WAKE_CYCLES(WAKE_CYCLES)
   ) dut_a (
      .clk(clk), .rst(rst), .CONVST(CONVST), .CS(CS), .RD(RD), .WR(WR),
      .SHDN(SHDN), .sample_in(sample_in), .sample_sel(sample_sel),
      .DB_out(db_out_a), .DB_oe(db_oe_a), .EOC(eoc_a), .overrun(ovr_a)
   );

   // Second instance with the ramp starting at 0xFFFF to exercise the wrap.
   adc_par16_responder #(
      .CONV_CYCLES(CONV_CYCLES),
      .WAKE_CYCLES(WAKE_CYCLES),
      .RAMP_INIT(RAMP_INIT_B)
   ) dut_b (
      .clk(clk), .rst(rst), .CONVST(CONVST), .CS(CS), .RD(RD), .WR(WR),
      .SHDN(SHDN), .sample_in(sample_in), .sample_sel(sample_sel),
      .DB_out(db_out_b), .DB_oe(db_oe_b), .EOC(eoc_b), .overrun(ovr_b)
   );

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
   endtask

   task automatic check_eoc(input string name, input logic exp);
      check({name, "_a"}, 16'(eoc_a), 16'(exp));
      check({name, "_b"}, 16'(eoc_b), 16'(exp));
   endtask

   task automatic check_ovr(input string name);
      check({name, "_a"}, 16'(ovr_a), 16'(m_ovr));
      check({name, "_b"}, 16'(ovr_b), 16'(m_ovr));
   endtask

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Conversion result as the converter defines it: the source at the start,
   // the ramp being the number of completed conversions since reset.
   task automatic model_start(input bit sel, input logic [15:0] samp);
      if (m_unread) m_ovr = 1'b1;
      m_data_a = sel ? samp : m_ramp;
      m_data_b = sel ? samp : 16'(m_ramp + RAMP_INIT_B);
      m_ramp   = m_ramp + 16'd1;
      m_unread = 1'b1;
   endtask

   task automatic model_reset();
      m_ramp   = 16'h0000;
      m_data_a = 16'h0000;
      m_data_b = 16'h0000;
      m_unread = 1'b0;
      m_ovr    = 1'b0;
   endtask

   // CONVST sampled at edge k: EOC must still be high after k+9 and low after k+10.
   task automatic do_conv(input bit sel, input logic [15:0] samp,
                          input logic [15:0] late, input bit pulse);
      @(negedge clk);
      sample_sel = sel;
      sample_in  = samp;
      CONVST     = 1'b0;
      model_start(sel, samp);
      wait_neg(3);
      CONVST = 1'b1;
      wait_neg(1);
      sample_in = late;
      if (pulse) begin
         wait_neg(1);
         CONVST = 1'b0;
         m_ovr  = 1'b1;
         wait_neg(2);
         CONVST = 1'b1;
         wait_neg(3);
      end else begin
         wait_neg(6);
      end
      check_eoc("eoc_busy", 1'b1);
      wait_neg(1);
      check_eoc("eoc_done", 1'b0);
      check_ovr("overrun");
   endtask

   task automatic do_read();
      @(negedge clk);
      exp_a.push_back(m_data_a);
      exp_b.push_back(m_data_b);
      CS = 1'b0;
      RD = 1'b0;
      if (m_unread) begin
         wait_neg(2);
         check_eoc("eoc_rd_hold", 1'b0);
         wait_neg(1);
         check_eoc("eoc_rd_release", 1'b1);
         wait_neg(3);
      end else begin
         wait_neg(6);
      end
      CS = 1'b1;
      RD = 1'b1;
      m_unread = 1'b0;
      wait_neg(5);
   endtask

   // Monitor: every DB_oe rise presents one read; DB must return to zero on release.
   logic        oe_prev = 1'b0;
   logic [15:0] pop_a, pop_b;
   always @(negedge clk) begin
      if (db_oe_a && !oe_prev) begin
         if (exp_a.size() == 0) begin
            n_total++;
            $display("FAIL rd_unexpected: got read 0x%04h expected no read at %0t", db_out_a, $time);
         end else begin
            pop_a = exp_a.pop_front();
            pop_b = exp_b.pop_front();
            check("rd_data_a", db_out_a, pop_a);
            check("rd_data_b", db_out_b, pop_b);
            check("rd_oe_b", 16'(db_oe_b), 16'd1);
         end
      end
      if (!db_oe_a && oe_prev) check("rd_release_zero", db_out_a, 16'h0000);
      oe_prev = db_oe_a;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish by %0t", $time);
      $fatal(1, "watchdog expired");
   end

   bit          r_sel;
   logic [15:0] r_samp, r_late;

   initial begin
      wait_neg(4);
      rst = 1'b0;
      wait_neg(1);
      check_eoc("rst_eoc", 1'b1);
      check("rst_oe", 16'(db_oe_a), 16'd0);
      check("rst_db", db_out_a, 16'h0000);
      check_ovr("rst_overrun");

      // read before any conversion returns zero
      do_read();

      // ramp mode: A reads 0 then 1, B reads 0xFFFF then 0x0000
      do_conv(1'b0, 16'h0000, 16'h0000, 1'b0);
      do_read();
      do_conv(1'b0, 16'h0000, 16'h0000, 1'b0);
      do_read();

      // external sample captured at start, later change ignored
      do_conv(1'b1, 16'hA5C3, 16'h1234, 1'b0);
      do_read();

      // CONVST 3 cycles into CONVERT: no restart, overrun sticks
      do_conv(1'b0, 16'h0000, 16'h0000, 1'b1);
      do_read();

      for (int i = 0; i < 30; i++) begin
         r_sel  = 1'($urandom_range(0, 1));
         r_samp = 16'($urandom);
         r_late = 16'($urandom);
         do_conv(r_sel, r_samp, r_late, 1'b0);
         if ($urandom_range(0, 3) != 0) do_read();
         wait_neg($urandom_range(0, 3));
      end
      do_read();

      // shutdown mid-conversion aborts; CONVST during wake is ignored
      @(negedge clk);
      sample_sel = 1'b0;
      CONVST = 1'b0;
      wait_neg(3);
      CONVST = 1'b1;
      wait_neg(1);
      SHDN = 1'b1;
      wait_neg(8);
      check_eoc("shdn_eoc", 1'b1);
      wait_neg(8);
      check_eoc("shdn_eoc_hold", 1'b1);
      SHDN = 1'b0;
      wait_neg(1);
      CONVST = 1'b0;
      wait_neg(2);
      CONVST = 1'b1;
      wait_neg(13);
      check_eoc("wake_convst_ignored", 1'b1);
      m_unread = 1'b0;
      do_conv(1'b0, 16'h0000, 16'h0000, 1'b0);
      do_read();

      // reset mid-conversion while a read is active
      @(negedge clk);
      exp_a.push_back(m_data_a);
      exp_b.push_back(m_data_b);
      CS = 1'b0;
      RD = 1'b0;
      wait_neg(5);
      sample_sel = 1'b0;
      CONVST = 1'b0;
      wait_neg(3);
      CONVST = 1'b1;
      wait_neg(2);
      rst = 1'b1;
      wait_neg(1);
      check_eoc("rst_mid_eoc", 1'b1);
      rst = 1'b0;
      CS = 1'b1;
      RD = 1'b1;
      model_reset();
      wait_neg(1);
      check("rst_mid_oe", 16'(db_oe_a), 16'd0);
      check("rst_mid_db", db_out_a, 16'h0000);
      check_ovr("rst_mid_overrun");
      wait_neg(12);
      check_eoc("rst_discarded", 1'b1);
      do_conv(1'b0, 16'h0000, 16'h0000, 1'b0);
      do_read();

      wait_neg(10);
      check("scoreboard_drained", 16'(exp_a.size()), 16'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
